// File: rtl/axi4_rd_responder_if.sv
// rtl/axi4_rd_responder_if.sv - AXI4 bundle (axi4_if) with master/slave modports; write channels reduced to handshakes
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic                  awvalid;
    logic                  awready;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
               awvalid, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
               awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
               awvalid, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid,
               awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi4_rd_responder.sv
// rtl/axi4_rd_responder.sv - AXI4 read-only responder over a word array; optional AXI_RD_RANDOM_STALL_EN inserts LFSR bubbles
module axi4_rd_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ID_WIDTH    = 4,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h3000_0000),
    parameter int                    LATENCY     = 2,
    parameter string                 INIT_FILE   = ""
) (
    input  logic   clock,
    input  logic   reset,
    axi4_if.slave  s_axi,
    output logic   busy
);
    localparam int                    IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);
    localparam logic [7:0]            LAT8    = 8'(LATENCY);
    localparam logic [1:0]            OKAY    = 2'b00;
    localparam logic [1:0]            SLVERR  = 2'b10;
    localparam logic [1:0]            DECERR  = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [1:0]            size;
    logic [1:0]            burst;
    logic [7:0]            beat;
    logic [7:0]            lat_cnt;

    logic                  r_valid;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  stall;

`ifdef AXI_RD_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Address advance on the aligned beat address.
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] nxt_addr;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        nxt_addr  = addr + step;
        case (burst)
            2'b00:   nxt_addr = addr;
            2'b10:   nxt_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default: nxt_addr = addr + step;
        endcase
    end

    // Fetch the beat about to be presented: the next one after a handshake, else the current one.
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] rd_off;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [1:0]            rd_resp;
    logic [7:0]            beat_sel;

    always_comb begin
        rd_addr  = r_valid ? nxt_addr : addr;
        beat_sel = r_valid ? 8'(beat + 8'd1) : beat;
        rd_off   = rd_addr - BASE_ADDR;
        rd_hit   = (rd_addr >= BASE_ADDR) && ((rd_off >> 2) < DEPTH_A);
        rd_word  = rd_hit ? mem[rd_off[IDX_W+1:2]] : '0;
        if (burst == 2'b11) rd_resp = SLVERR;
        else if (rd_hit)    rd_resp = OKAY;
        else                rd_resp = DECERR;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            len     <= '0;
            size    <= '0;
            burst   <= '0;
            beat    <= '0;
            lat_cnt <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_resp  <= OKAY;
            r_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    if (s_axi.arvalid) begin
                        addr    <= {s_axi.araddr[ADDR_WIDTH-1:2], 2'b00};
                        len     <= s_axi.arlen;
                        size    <= (s_axi.arsize > 3'd2) ? 2'd2 : s_axi.arsize[1:0];
                        burst   <= s_axi.arburst;
                        r_id    <= s_axi.arid;
                        beat    <= '0;
                        lat_cnt <= LAT8;
                        state   <= (LATENCY == 0) ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 8'd1;
                    if (lat_cnt == 8'd1) state <= BURST;
                end
                BURST: begin
                    if (!r_valid) begin
                        if (!stall) begin
                            r_valid <= 1'b1;
                            r_data  <= rd_word;
                            r_resp  <= rd_resp;
                            r_last  <= (beat_sel == len);
                        end
                    end else if (s_axi.rready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            addr <= nxt_addr;
                            beat <= beat_sel;
                            if (!stall) begin
                                r_data <= rd_word;
                                r_resp <= rd_resp;
                                r_last <= (beat_sel == len);
                            end else begin
                                r_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_axi.arready = ~reset & (state == IDLE);
    assign s_axi.rvalid  = r_valid;
    assign s_axi.rlast   = r_last;
    assign s_axi.rdata   = r_data;
    assign s_axi.rresp   = r_resp;
    assign s_axi.rid     = r_id;
    assign busy          = (state != IDLE);

    assign s_axi.awready = 1'b0;
    assign s_axi.wready  = 1'b0;
    assign s_axi.bvalid  = 1'b0;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.bid     = '0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, s_axi.awvalid, s_axi.wvalid, s_axi.bready, s_axi.araddr[1:0]};
endmodule

// File: tb/tb_axi4_rd_responder.sv
// tb/tb_axi4_rd_responder.sv - directed self-checking bench for axi4_rd_responder
module tb_axi4_rd_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic busy;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi4_rd_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .DEPTH_WORDS(1024),
        .BASE_ADDR(32'h3000_0000), .LATENCY(2), .INIT_FILE("")
    ) dut (
        .clock(clock),
        .reset(reset),
        .s_axi(bus),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_d [16];
    logic [1:0]  exp_r;
    int          lat;
    int          bub;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ar_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                          input logic [1:0] b, input logic [3:0] id);
        @(negedge clock);
        bus.araddr  = a;
        bus.arlen   = l;
        bus.arsize  = sz;
        bus.arburst = b;
        bus.arid    = id;
        bus.arvalid = 1'b1;
        check("arready_idle", 32'(bus.arready), 32'd1);
        @(negedge clock);
        bus.arvalid = 1'b0;
    endtask

    task automatic collect(input int n, input bit toggle, input logic [3:0] id,
                           output int lat_o, output int bub_o);
        int beat    = 0;
        int cyc     = 0;
        bit started = 1'b0;
        lat_o = 0;
        bub_o = 0;
        while (beat < n && cyc < 300) begin
            bus.rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (bus.rvalid) begin
                started = 1'b1;
                check("rdata", bus.rdata, exp_d[beat]);
                check("rresp", 32'(bus.rresp), 32'(exp_r));
                check("rlast", 32'(bus.rlast), 32'(beat == n - 1));
                check("rid", 32'(bus.rid), 32'(id));
                if (bus.rready) beat++;
            end else if (started) begin
                bub_o++;
            end else begin
                lat_o++;
            end
            cyc++;
            @(negedge clock);
        end
        bus.rready = 1'b1;
        check("beat_count", 32'(beat), 32'(n));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_arready"}, 32'(bus.arready), 32'd1);
        check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bus.arvalid = 1'b0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsize  = '0;
        bus.arburst = '0;
        bus.arid    = '0;
        bus.rready  = 1'b1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        for (int i = 0; i < 1024; i++) dut.mem[i] = 32'(i);
        dut.mem[0] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clock);
        check("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rlast", 32'(bus.rlast), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_rid", 32'(bus.rid), 32'd0);
        check("rst_rresp", 32'(bus.rresp), 32'd0);
        check("tie_awready", 32'(bus.awready), 32'd0);
        check("tie_bvalid", 32'(bus.bvalid), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_arready", 32'(bus.arready), 32'd1);

        // Single beat
        exp_d[0] = 32'hDEAD_BEEF;
        exp_r    = 2'b00;
        ar_req(32'h3000_0000, 8'd0, 3'd2, 2'b01, 4'd3);
        collect(1, 1'b0, 4'd3, lat, bub);
`ifndef AXI_RD_RANDOM_STALL_EN
        check("latency", 32'(lat), 32'd3);
`endif
        check_idle("single");

        // Icache refill, continuous rready then toggling rready
        for (int i = 0; i < 8; i++) exp_d[i] = 32'(8 + i);
        ar_req(32'h3000_0020, 8'd7, 3'd2, 2'b01, 4'd5);
        collect(8, 1'b0, 4'd5, lat, bub);
`ifndef AXI_RD_RANDOM_STALL_EN
        check("refill_bubbles", 32'(bub), 32'd0);
`endif
        check_idle("refill");
        ar_req(32'h3000_0020, 8'd7, 3'd2, 2'b01, 4'd6);
        collect(8, 1'b1, 4'd6, lat, bub);
        check_idle("refill_stall");

        // WRAP
        exp_d[0] = 32'd2;
        exp_d[1] = 32'd3;
        exp_d[2] = 32'hDEAD_BEEF;
        exp_d[3] = 32'd1;
        ar_req(32'h3000_0008, 8'd3, 3'd2, 2'b10, 4'd1);
        collect(4, 1'b0, 4'd1, lat, bub);

        // FIXED
        for (int i = 0; i < 3; i++) exp_d[i] = 32'd1;
        ar_req(32'h3000_0004, 8'd2, 3'd2, 2'b00, 4'd2);
        collect(3, 1'b0, 4'd2, lat, bub);

        // Decode errors below base and just past the top
        exp_d[0] = 32'd0;
        exp_d[1] = 32'd0;
        exp_r    = 2'b11;
        ar_req(32'h2000_0000, 8'd1, 3'd2, 2'b01, 4'd4);
        collect(2, 1'b0, 4'd4, lat, bub);
        ar_req(32'h3000_1000, 8'd1, 3'd2, 2'b01, 4'd4);
        collect(2, 1'b0, 4'd4, lat, bub);

        // Reserved burst type reports SLVERR
        exp_d[0] = 32'd4;
        exp_d[1] = 32'd5;
        exp_r    = 2'b10;
        ar_req(32'h3000_0010, 8'd1, 3'd2, 2'b11, 4'd7);
        collect(2, 1'b0, 4'd7, lat, bub);

        // Unaligned start address
        exp_r = 2'b00;
        ar_req(32'h3000_0013, 8'd1, 3'd2, 2'b01, 4'd8);
        collect(2, 1'b0, 4'd8, lat, bub);
        check_idle("unaligned");

        // Reset during the third beat
        begin
            int hs = 0;
            int t  = 0;
            int late = 0;
            ar_req(32'h3000_0020, 8'd7, 3'd2, 2'b01, 4'd9);
            while (t < 100 && !(bus.rvalid && hs == 2)) begin
                if (bus.rvalid) hs++;
                t++;
                @(negedge clock);
            end
            check("mid_beat3_reached", 32'(bus.rvalid && hs == 2), 32'd1);
            check("mid_beat3_data", bus.rdata, 32'd10);
            reset = 1'b1;
            #1;
            check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
            check("mid_rst_rlast", 32'(bus.rlast), 32'd0);
            check("mid_rst_rdata", bus.rdata, 32'd0);
            check("mid_rst_arready", 32'(bus.arready), 32'd0);
            check("mid_rst_busy", 32'(busy), 32'd0);
            @(negedge clock);
            reset = 1'b0;
            #1;
            check("mid_rel_arready", 32'(bus.arready), 32'd1);
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                if (bus.rvalid) late++;
            end
            check("mid_no_stale_beats", 32'(late), 32'd0);
            exp_d[0] = 32'd4;
            ar_req(32'h3000_0010, 8'd0, 3'd2, 2'b01, 4'd10);
            collect(1, 1'b0, 4'd10, lat, bub);
            check_idle("after_rst");
        end

`ifdef AXI_RD_RANDOM_STALL_EN
        for (int i = 0; i < 16; i++) exp_d[i] = 32'(16 + i);
        ar_req(32'h3000_0040, 8'd15, 3'd2, 2'b01, 4'd11);
        collect(16, 1'b0, 4'd11, lat, bub);
        check("stall_bubble_seen", 32'(bub > 0), 32'd1);
        check_idle("stall");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
